// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM sequencing a multicycle RV32I datapath
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Illegal
// opcodes and bus timeouts park the FSM in TRAP until reset.
//
// Ports:
//   i_clk, i_reset            clock (rising edge), asynchronous active-low reset
//   i_inst[31:0]              instruction register contents, valid from DECODE
//   i_imem_ready              instruction fetch complete (sampled in FETCH)
//   i_dmem_ready              data access complete (sampled in MEM)
//   i_br_equal, i_br_less     branch comparator results
//   o_imem_req, o_ir_en       instruction request, IR load strobe
//   o_dmem_req, o_dmem_wren   data request, data write
//   o_pc_en, o_pc_sel         PC strobe, next-PC select (0 PC+4, 1 ALU)
//   o_opa_sel, o_opb_sel      ALU operand selects (A: rs1/PC, B: rs2/imm)
//   o_br_un                   unsigned branch compare
//   o_imm_sel[2:0]            immediate format select
//   o_rd_wren, o_wb_sel[1:0]  register write enable, writeback source
//   o_illegal, o_bus_err      sticky trap causes
//   o_state[2:0]              encoded state
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_inst,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    input  logic        i_br_equal,
    input  logic        i_br_less,
    output logic        o_imem_req,
    output logic        o_ir_en,
    output logic        o_dmem_req,
    output logic        o_dmem_wren,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic        o_opa_sel,
    output logic        o_opb_sel,
    output logic        o_br_un,
    output logic [2:0]  o_imm_sel,
    output logic        o_rd_wren,
    output logic [1:0]  o_wb_sel,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic [2:0]  o_state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic             illegal_q, illegal_nxt;
    logic             bus_err_q, bus_err_nxt;

    // Only opcode and funct3 are decoded here; the rest of the word belongs
    // to the datapath.
    logic unused_inst;
    assign unused_inst = ^{i_inst[31:15], i_inst[11:7]};

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE,
            OP_OP, OP_LUI, OP_JALR, OP_JAL: is_legal = 1'b1;
            OP_BRANCH:                      is_legal = (f3[2:1] != 2'b01);
            default:                        is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_of = 3'b001;
            OP_BRANCH: imm_of = 3'b010;
            OP_JAL:    imm_of = 3'b011;
            OP_LUI:    imm_of = 3'b100;
            OP_AUIPC:  imm_of = 3'b101;
            default:   imm_of = 3'b000;
        endcase
    endfunction

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_rtype;
    logic timed_out, taken;

    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_branch = (op_q == OP_BRANCH);
    assign is_jal    = (op_q == OP_JAL);
    assign is_jalr   = (op_q == OP_JALR);
    assign is_auipc  = (op_q == OP_AUIPC);
    assign is_rtype  = (op_q == OP_OP);

    // The wait that would make TIMEOUT consecutive not-ready cycles traps;
    // a ready in that same cycle is accepted instead.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        taken = 1'b0;
        case (f3_q)
            3'b000:         taken = i_br_equal;
            3'b001:         taken = !i_br_equal;
            3'b100, 3'b110: taken = i_br_less;
            3'b101, 3'b111: taken = !i_br_less;
            default:        taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            op_q      <= '0;
            f3_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            illegal_q <= illegal_nxt;
            bus_err_q <= bus_err_nxt;
            if (state == S_DECODE) begin
                op_q <= i_inst[6:0];
                f3_q <= i_inst[14:12];
            end
        end
    end

    // Next state. The wait counter is zero in every state except while a
    // FETCH or MEM access is stalled, so it starts clean on each entry.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        illegal_nxt  = illegal_q;
        bus_err_nxt  = bus_err_q;
        case (state)
            S_FETCH: begin
                if (i_imem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt   = S_TRAP;
                    bus_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (!is_legal(i_inst[6:0], i_inst[14:12])) begin
                    state_nxt   = S_TRAP;
                    illegal_nxt = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch)
                    state_nxt = S_FETCH;
                else if (is_load || is_store)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (i_dmem_ready) begin
                    state_nxt = is_store ? S_FETCH : S_WB;
                end else if (timed_out) begin
                    state_nxt   = S_TRAP;
                    bus_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs come from state and the latched opcode/funct3. The exceptions
    // are the strobes that must coincide with a completing access or a
    // branch decision, and the immediate select in DECODE, which reads the
    // freshly loaded IR because the opcode latch fills only at its end.
    always_comb begin
        o_imem_req  = 1'b0;
        o_ir_en     = 1'b0;
        o_dmem_req  = 1'b0;
        o_dmem_wren = 1'b0;
        o_pc_en     = 1'b0;
        o_pc_sel    = 1'b0;
        o_opa_sel   = 1'b0;
        o_opb_sel   = 1'b0;
        o_br_un     = 1'b0;
        o_rd_wren   = 1'b0;
        o_wb_sel    = 2'b00;
        o_imm_sel   = imm_of((state == S_DECODE) ? i_inst[6:0] : op_q);
        case (state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_ir_en    = i_imem_ready;
            end
            S_EXEC: begin
                o_opa_sel = is_auipc || is_jal || is_branch;
                o_opb_sel = !is_rtype;
                if (is_branch) begin
                    o_br_un  = f3_q[1];
                    o_pc_en  = 1'b1;
                    o_pc_sel = taken;
                end
            end
            S_MEM: begin
                o_dmem_req  = 1'b1;
                o_dmem_wren = is_store;
                o_pc_en     = is_store && i_dmem_ready;
            end
            S_WB: begin
                o_rd_wren = 1'b1;
                o_pc_en   = 1'b1;
                o_pc_sel  = is_jal || is_jalr;
                if (is_load)
                    o_wb_sel = 2'b01;
                else if (is_jal || is_jalr)
                    o_wb_sel = 2'b10;
            end
            default: ;
        endcase
    end

    assign o_illegal = illegal_q;
    assign o_bus_err = bus_err_q;
    assign o_state   = state;

endmodule
